// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/branch controls in, instruction memory port,
// and the IF/ID register outputs toward decode.
// Optional FETCH_PERF_CNT_EN adds the fetch/stall performance counters.
interface fetch_if;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] pc_out;
    logic [15:0] ifid_inst;
    logic [15:0] ifid_pc1;
    logic        ifid_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    // Environment side: drives controls and memory data, observes fetch.
    modport master (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_addr, pc_out, ifid_inst, ifid_pc1, ifid_valid, halted
`ifdef FETCH_PERF_CNT_EN
        , input fetch_count, stall_count
`endif
    );

    // Fetch stage side.
    modport slave (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_addr, pc_out, ifid_inst, ifid_pc1, ifid_valid, halted
`ifdef FETCH_PERF_CNT_EN
        , output fetch_count, stall_count
`endif
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction memory addressing and
// the IF/ID pipeline register. Redirect beats stall beats HALT beats fetch.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INST    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic   clk,
    input  logic   rst,
    fetch_if.slave bus
);
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] pc1_q, pc1_d;
    logic        valid_q, valid_d;
    logic [15:0] pc_inc;
    logic        fetch_en;

    assign pc_inc   = pc_q + 16'd1;
    // A real instruction enters IF/ID only when running and unobstructed.
    assign fetch_en = !bus.redirect && !bus.stall && (state_q == RUN);

    // State, PC and IF/ID registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            pc1_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc1_q   <= pc1_d;
            valid_q <= valid_d;
        end
    end

    // Next-state: redirect squashes, stall holds, HALT emits bubbles.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        pc1_d   = pc1_q;
        valid_d = valid_q;
        if (bus.redirect) begin
            pc_d    = bus.redirect_pc;
            inst_d  = NOP_INST;
            pc1_d   = 16'h0000;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (bus.stall) begin
            // everything holds
        end else if (state_q == HALT) begin
            inst_d  = NOP_INST;
            pc1_d   = 16'h0000;
            valid_d = 1'b0;
        end else begin
            inst_d  = bus.imem_rdata;
            pc1_d   = pc_inc;
            valid_d = 1'b1;
            // The HALT word itself goes to decode; PC parks on it.
            if (bus.imem_rdata[15:12] == HALT_OPCODE)
                state_d = HALT;
            else
                pc_d = pc_inc;
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.pc_out     = pc_q;
    assign bus.ifid_inst  = inst_q;
    assign bus.ifid_pc1   = pc1_q;
    assign bus.ifid_valid = valid_q;
    assign bus.halted     = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, stall_cnt_q;

    // Saturating counters of fetched instructions and stalled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= 16'h0000;
            stall_cnt_q <= 16'h0000;
        end else begin
            if (fetch_en && fetch_cnt_q != 16'hFFFF)
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            if (bus.stall && !bus.redirect && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.fetch_count = fetch_cnt_q;
    assign bus.stall_count = stall_cnt_q;
`else
    logic unused_fetch_en;
    assign unused_fetch_en = fetch_en;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random
// stall/redirect/HALT traffic against a cycle-level behavioural model.
// Also checks a second instance with RESET_PC=16'hFFFF for PC wrap.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];

    fetch_if bus ();
    fetch_if bus2 ();

    assign bus.imem_rdata  = mem[bus.imem_addr];
    assign bus2.imem_rdata = mem[bus2.imem_addr];

    fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));
    fetch_stage #(.RESET_PC(16'hFFFF)) dut_wrap (.clk(clk), .rst(rst), .bus(bus2));

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] m_pc, m_inst, m_pc1;
    logic        m_valid, m_halt;
    int          m_fc, m_sc;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_inst = 16'h0000; m_pc1 = 16'h0000;
        m_valid = 1'b0; m_halt = 1'b0; m_fc = 0; m_sc = 0;
    endtask

    task automatic check_all(input string where);
        chk({where, ".pc"},    bus.pc_out,    m_pc);
        chk({where, ".addr"},  bus.imem_addr, m_pc);
        chk({where, ".inst"},  bus.ifid_inst, m_inst);
        chk({where, ".pc1"},   bus.ifid_pc1,  m_pc1);
        chk({where, ".valid"}, {15'b0, bus.ifid_valid}, {15'b0, m_valid});
        chk({where, ".halted"},{15'b0, bus.halted},     {15'b0, m_halt});
`ifdef FETCH_PERF_CNT_EN
        chk({where, ".fcnt"},  bus.fetch_count, 16'(m_fc));
        chk({where, ".scnt"},  bus.stall_count, 16'(m_sc));
`endif
    endtask

    // One clock: apply inputs, predict, clock, compare.
    task automatic step(input logic s, input logic r, input logic [15:0] rp);
        logic [15:0] word;
        bus.stall = s; bus.redirect = r; bus.redirect_pc = rp;
        #1;
        chk("pre.addr", bus.imem_addr, m_pc);
        word = mem[m_pc];
        if (r) begin
            m_pc = rp; m_inst = 16'h0000; m_pc1 = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
        end else if (s) begin
            if (m_sc < 65535) m_sc++;
        end else if (m_halt) begin
            m_inst = 16'h0000; m_pc1 = 16'h0000; m_valid = 1'b0;
        end else begin
            m_inst = word; m_pc1 = m_pc + 16'd1; m_valid = 1'b1;
            if (m_fc < 65535) m_fc++;
            if (word[15:12] == 4'hF) m_halt = 1'b1;
            else m_pc = m_pc + 16'd1;
        end
        @(posedge clk); #1;
        check_all("step");
    endtask

    // Async reset asserted between edges, checked before any clock edge.
    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 + 16'(i & 16'h0FFF);
    endtask

    initial begin
        fill_linear();
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 16'h0000;
        bus2.stall = 1'b0; bus2.redirect = 1'b0; bus2.redirect_pc = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("wrap.rst_pc", bus2.pc_out, 16'hFFFF);
        @(negedge clk);
        rst = 1'b1;

        // free run: 1000, 1001, ... with pc1 1, 2, ...
        step(0, 0, 0);
        chk("wrap.pc1_0", bus2.ifid_pc1, 16'h0000);
        chk("wrap.inst_0", bus2.ifid_inst, 16'h1FFF);
        chk("wrap.addr_1", bus2.imem_addr, 16'h0000);
        step(0, 0, 0);
        chk("wrap.inst_1", bus2.ifid_inst, 16'h1000);
        chk("wrap.pc1_1", bus2.ifid_pc1, 16'h0001);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        chk("run.inst4", bus.ifid_inst, 16'h1004);
        chk("run.pc", bus.pc_out, 16'h0005);

        // stall 3 cycles at PC=5, then resume with imem[5]
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        chk("stall.inst", bus.ifid_inst, 16'h1004);
        step(0, 0, 0);
        chk("stall.resume", bus.ifid_inst, 16'h1005);

        // redirect beats stall
        step(1, 1, 16'h0040);
        chk("redir.pc", bus.pc_out, 16'h0040);
        chk("redir.bubble", {15'b0, bus.ifid_valid}, 16'h0000);
        step(0, 0, 0);
        chk("redir.inst", bus.ifid_inst, 16'h1040);
        chk("redir.pc1", bus.ifid_pc1, 16'h0041);

        // HALT at address 3
        mem[3] = 16'hF000;
        step(0, 1, 16'h0000);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        chk("halt.inst", bus.ifid_inst, 16'hF000);
        chk("halt.flag", {15'b0, bus.halted}, 16'h0001);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(1, 0, 0);
        chk("halt.pc", bus.pc_out, 16'h0003);
        step(0, 1, 16'h0010);
        chk("halt.clear", {15'b0, bus.halted}, 16'h0000);
        step(0, 0, 0);
        chk("halt.resume", bus.ifid_inst, 16'h1010);

        // back into HALT, then reset with redirect and stall high
        step(0, 1, 16'h0002);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        bus.redirect = 1'b1; bus.stall = 1'b1; bus.redirect_pc = 16'h0077;
        async_reset();
        bus.redirect = 1'b0; bus.stall = 1'b0;
        mem[3] = 16'h1003;

`ifdef FETCH_PERF_CNT_EN
        // 10 fetches, 4 stalls, 1 redirect
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        step(0, 1, 16'h0020);
        chk("perf.fetch", bus.fetch_count, 16'd10);
        chk("perf.stall", bus.stall_count, 16'd4);
        async_reset();
`endif

        // random traffic
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? 16'hF000 | 16'($urandom_range(0, 4095))
                                                  : 16'($urandom_range(0, 16'hEFFF));
        for (int i = 0; i < 600; i++) begin
            logic s, r;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 9) == 0);
            step(s, r, 16'($urandom_range(0, 255)));
            if (i == 300) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
